strobe_stretcher: RTL and testbench
===================================

// Module: strobe_stretcher
// PURPOSE
//   Output-side counterpart of the button synchronizer/edge detector: turns 1-cycle
//   internal strobes into visible, fixed-width pulses on an FPGA pin (LED/probe).
//   Strobes arriving while a pulse is in progress are queued in a saturating counter
//   and replayed back-to-back, separated by a guaranteed low gap, so none are merged.
// PARAMETERS
//   HIGH_CYCLES  4  cycles pulse_o is held high per strobe (>=1)
//   GAP_CYCLES   2  minimum low cycles between consecutive pulses (>=1)
//   PEND_W       3  width of pending-strobe counter; saturates at 2**PEND_W-1
// PORTS
//   clk         in   1       system clock; all logic on posedge
//   nrst        in   1       reset, synchronous, active-low
//   strobe_i    in   1       request; each cycle sampled high = one strobe (already synced)
//   pulse_o     out  1       stretched output pulse, registered
//   busy_o      out  1       high whenever state != IDLE, registered
//   pending_o   out  PEND_W  queued strobes not yet started
//   overflow_o  out  1       sticky: a strobe was dropped at saturation; cleared by reset only
// BEHAVIOUR
//   - Reset (nrst low at posedge): state=IDLE, timer=0, pending_o=0, pulse_o=0,
//     busy_o=0, overflow_o=0. Reset mid-pulse or mid-gap aborts and drops the queue.
//   - FSM states IDLE, HIGH, GAP; timer counts cycles spent in HIGH/GAP, width
//     $clog2(max(HIGH_CYCLES,GAP_CYCLES))+1.
//   - IDLE: strobe_i=1 -> HIGH next cycle (latency 1: strobe in cycle t, pulse_o=1
//     from t+1). pending unchanged.
//   - HIGH: pulse_o=1 for exactly HIGH_CYCLES cycles, then -> GAP.
//   - GAP: pulse_o=0 for exactly GAP_CYCLES cycles. On the last GAP cycle,
//     demand = pending + strobe_i; demand>0 -> HIGH next cycle, pending <= demand-1;
//     else -> IDLE.
//   - Strobes during HIGH or GAP (except last-GAP case above): pending+1.
//   - Saturation: pending == 2**PEND_W-1 and a strobe must be queued -> pending holds,
//     overflow_o <= 1. Last-GAP consume + new strobe at saturation: net unchanged, no
//     overflow.
//   - busy_o = (state != IDLE), updated with state. pulse_o never glitches; width and
//     gap are exact regardless of strobe_i activity.
//   - No arithmetic wrap: pending never wraps past max nor below 0.
// TESTING  (HIGH_CYCLES=4, GAP_CYCLES=2, PEND_W=2; cycle n = after posedge n)
//   1 nrst=0 for 2 cycles, strobe_i toggling -> pulse_o=0, busy_o=0, pending_o=0, overflow_o=0.
//   2 single strobe cycle 10 -> pulse_o=1 cycles 11-14, 0 at 15-16 with busy_o=1, busy_o=0 at 17.
//   3 strobes cycles 10,12 -> pulses 11-14 and 17-20; pending_o=1 cycles 13-16, 0 from 17.
//   4 strobes cycles 10-15 (6) -> pending_o saturates at 3, overflow_o=1 stays set;
//     exactly 4 pulses total (11-14,17-20,23-26,29-32); busy_o=0 at 35.
//   5 strobes cycles 10 and 16 (last GAP cycle, pending 0) -> pulses 11-14 and 17-20, no IDLE between.
//   6 strobes 10,11; nrst=0 cycle 13 -> pulse_o=0, pending_o=0, busy_o=0 at 14;
//     strobe at 20 -> pulse 21-24 as in scenario 2.

Source files
------------

// File: rtl/strobe_stretcher.sv
// ---------------------------------------------------------------------------
// strobe_stretcher
//
// Purpose:
//   Turns single-cycle internal strobes into fixed-width, visible pulses on an
//   output pin (LED / scope probe). A strobe that arrives while a pulse or its
//   trailing low gap is in progress is queued in a saturating counter. Queued
//   strobes are replayed back-to-back, each separated by a guaranteed low gap,
//   so no two strobes are ever merged into one longer pulse.
//
// Parameters:
//   HIGH_CYCLES  cycles pulse_o stays high per strobe (>= 1)
//   GAP_CYCLES   minimum low cycles between consecutive pulses (>= 1)
//   PEND_W       width of the pending-strobe counter (saturates at 2**PEND_W-1)
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   nrst         synchronous active-low reset
//   strobe_i     one strobe per cycle sampled high (already synchronised)
//   pulse_o      stretched output pulse, registered
//   busy_o       high whenever the FSM is not idle, registered
//   pending_o    strobes queued but not yet started
//   overflow_o   sticky flag: a strobe was dropped at saturation
// ---------------------------------------------------------------------------
module strobe_stretcher #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              strobe_i,
  output logic              pulse_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              overflow_o
);

  localparam int MAX_CYC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int TW      = $clog2(MAX_CYC) + 1;

  localparam logic [TW-1:0]     HIGH_LAST = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0]     GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [PEND_W-1:0] pend_q,  pend_d;
  logic              ovf_q,   ovf_d;
  logic              pulse_q, pulse_d;
  logic              busy_q,  busy_d;

  logic high_done;
  logic gap_done;
  logic demand_nz;

  assign high_done = (state_q == HIGH) && (timer_q == HIGH_LAST);
  assign gap_done  = (state_q == GAP)  && (timer_q == GAP_LAST);
  // demand = pending + strobe_i; only its non-zero-ness matters for the
  // transition, so no wide adder is needed.
  assign demand_nz = (pend_q != '0) || strobe_i;

  // -------------------------------------------------------------------------
  // State register (also holds timer, queue and registered outputs)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic: FSM, phase timer and pending queue
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    pend_d  = pend_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (strobe_i) begin
          state_d = HIGH;
        end
      end

      HIGH: begin
        if (high_done) begin
          state_d = GAP;
          timer_d = '0;
        end
      end

      GAP: begin
        if (gap_done) begin
          timer_d = '0;
          state_d = demand_nz ? HIGH : IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // Queue bookkeeping. On the last gap cycle one unit of demand is consumed
    // by the pulse that starts next; a coincident strobe replaces it, so the
    // count is unchanged (even at saturation, and without flagging overflow).
    if (gap_done) begin
      if (!strobe_i && (pend_q != '0)) begin
        pend_d = pend_q - PEND_ONE;
      end
    end else if ((state_q != IDLE) && strobe_i) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_ONE;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output logic: derived from the next state so the registered outputs line
  // up with the state register and never glitch.
  // -------------------------------------------------------------------------
  always_comb begin
    pulse_d = (state_d == HIGH);
    busy_d  = (state_d != IDLE);
  end

  assign pulse_o    = pulse_q;
  assign busy_o     = busy_q;
  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_strobe_stretcher.sv
// ---------------------------------------------------------------------------
// tb_strobe_stretcher
//
// Directed testbench for strobe_stretcher with HIGH_CYCLES=4, GAP_CYCLES=2,
// PEND_W=2. Cycle n is the state observed just after rising edge n following
// reset release; a strobe "in cycle t" is driven after edge t and therefore
// sampled at edge t+1. Each scenario compares {pulse, busy, pending, overflow}
// against hand-computed expectations every cycle.
// ---------------------------------------------------------------------------
module tb_strobe_stretcher;

  localparam int NC = 40;

  logic       clk;
  logic       nrst;
  logic       strobe_i;
  logic       pulse_o;
  logic       busy_o;
  logic [1:0] pending_o;
  logic       overflow_o;

  int checks;
  int failures;

  logic [4:0] obs_log [0:NC-1];

  strobe_stretcher #(
    .HIGH_CYCLES(4),
    .GAP_CYCLES (2),
    .PEND_W     (2)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .strobe_i  (strobe_i),
    .pulse_o   (pulse_o),
    .busy_o    (busy_o),
    .pending_o (pending_o),
    .overflow_o(overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic inr(input int n, input int lo, input int hi);
    return (n >= lo) && (n <= hi);
  endfunction

  // Reset for two edges, then run NC cycles logging outputs; smask/rmask
  // give per-cycle strobe and reset-assert requests.
  task automatic run_scenario(input logic [63:0] smask, input logic [63:0] rmask);
    nrst     = 1'b0;
    strobe_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    for (int n = 0; n < NC; n++) begin
      @(posedge clk);
      #1;
      obs_log[n] = {pulse_o, busy_o, pending_o, overflow_o};
      strobe_i   = smask[n];
      nrst       = !rmask[n];
    end
    strobe_i = 1'b0;
    nrst     = 1'b1;
  endtask

  task automatic test_reset;
    nrst     = 1'b0;
    strobe_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      strobe_i = ~strobe_i;
      checks++;
      if ({pulse_o, busy_o, pending_o, overflow_o} !== 5'b0) begin
        $display("FAIL reset edge=%0d got=%b exp=%b", k,
                 {pulse_o, busy_o, pending_o, overflow_o}, 5'b0);
        failures++;
      end
    end
    strobe_i = 1'b0;
    $display("scenario reset done checks=%0d", checks);
  endtask

  task automatic test_single;
    logic [63:0] sm;
    logic [63:0] rm;
    logic [4:0]  e;
    sm = '0; rm = '0;
    sm[10] = 1'b1;
    run_scenario(sm, rm);
    for (int n = 0; n < NC; n++) begin
      e = {inr(n, 11, 14), inr(n, 11, 16), 2'd0, 1'b0};
      checks++;
      if (obs_log[n] !== e) begin
        $display("FAIL single cyc=%0d got=%b exp=%b", n, obs_log[n], e);
        failures++;
      end
    end
    $display("scenario single done checks=%0d", checks);
  endtask

  task automatic test_queue_one;
    logic [63:0] sm;
    logic [63:0] rm;
    logic [4:0]  e;
    sm = '0; rm = '0;
    sm[10] = 1'b1;
    sm[12] = 1'b1;
    run_scenario(sm, rm);
    for (int n = 0; n < NC; n++) begin
      e = {inr(n, 11, 14) || inr(n, 17, 20), inr(n, 11, 22),
           inr(n, 13, 16) ? 2'd1 : 2'd0, 1'b0};
      checks++;
      if (obs_log[n] !== e) begin
        $display("FAIL queue_one cyc=%0d got=%b exp=%b", n, obs_log[n], e);
        failures++;
      end
    end
    $display("scenario queue_one done checks=%0d", checks);
  endtask

  task automatic test_saturation;
    logic [63:0] sm;
    logic [63:0] rm;
    logic [4:0]  e;
    logic [1:0]  pd;
    int          rises;
    sm = '0; rm = '0;
    for (int t = 10; t <= 15; t++) sm[t] = 1'b1;
    run_scenario(sm, rm);
    rises = 0;
    for (int n = 0; n < NC; n++) begin
      if (n == 12)             pd = 2'd1;
      else if (n == 13)        pd = 2'd2;
      else if (inr(n, 14, 16)) pd = 2'd3;
      else if (inr(n, 17, 22)) pd = 2'd2;
      else if (inr(n, 23, 28)) pd = 2'd1;
      else                     pd = 2'd0;
      e = {inr(n, 11, 14) || inr(n, 17, 20) || inr(n, 23, 26) || inr(n, 29, 32),
           inr(n, 11, 34), pd, (n >= 15)};
      checks++;
      if (obs_log[n] !== e) begin
        $display("FAIL saturation cyc=%0d got=%b exp=%b", n, obs_log[n], e);
        failures++;
      end
      if (n > 0 && obs_log[n][4] === 1'b1 && obs_log[n-1][4] === 1'b0) rises++;
    end
    checks++;
    if (rises !== 4) begin
      $display("FAIL saturation_pulse_count got=%0d exp=%0d", rises, 4);
      failures++;
    end
    $display("scenario saturation done checks=%0d", checks);
  endtask

  task automatic test_back_to_back;
    logic [63:0] sm;
    logic [63:0] rm;
    logic [4:0]  e;
    sm = '0; rm = '0;
    sm[10] = 1'b1;
    sm[16] = 1'b1;
    run_scenario(sm, rm);
    for (int n = 0; n < NC; n++) begin
      e = {inr(n, 11, 14) || inr(n, 17, 20), inr(n, 11, 22), 2'd0, 1'b0};
      checks++;
      if (obs_log[n] !== e) begin
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", n, obs_log[n], e);
        failures++;
      end
    end
    $display("scenario back_to_back done checks=%0d", checks);
  endtask

  task automatic test_mid_reset;
    logic [63:0] sm;
    logic [63:0] rm;
    logic [4:0]  e;
    sm = '0; rm = '0;
    sm[10] = 1'b1;
    sm[11] = 1'b1;
    sm[20] = 1'b1;
    rm[13] = 1'b1;
    run_scenario(sm, rm);
    for (int n = 0; n < NC; n++) begin
      e = {inr(n, 11, 13) || inr(n, 21, 24), inr(n, 11, 13) || inr(n, 21, 26),
           inr(n, 12, 13) ? 2'd1 : 2'd0, 1'b0};
      checks++;
      if (obs_log[n] !== e) begin
        $display("FAIL mid_reset cyc=%0d got=%b exp=%b", n, obs_log[n], e);
        failures++;
      end
    end
    $display("scenario mid_reset done checks=%0d", checks);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nrst     = 1'b0;
    strobe_i = 1'b0;
    test_reset();
    test_single();
    test_queue_one();
    test_saturation();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
